// File: rtl/clk_div_if.sv
// Bundle of run-control, configuration handshake and divided-clock outputs
// shared between the divider controller and whatever drives/consumes it.
interface clk_div_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [DIV_W-1:0] div_cur;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, clk_out, tick, running, div_cur
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, clk_out, tick, running, div_cur
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: glitch-free start/stop on period boundaries and
// divide-ratio changes deferred to the end of the running period.
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input logic      clk,
  input logic      rst_n,
  clk_div_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

  // Ratios below 2 cannot produce both a high and a low phase.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    logic [DIV_W-1:0] r;
    if (v < MIN_DIV) begin
      r = MIN_DIV;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [DIV_W-1:0] cnt_r, cnt_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic             pend_vld_r, pend_vld_s;
  logic [DIV_W-1:0] pend_div_r, pend_div_s;
  logic             clk_out_r, clk_out_s;
  logic             tick_r, tick_s;
  logic             running_r, running_s;
  logic             cfg_ready_r, cfg_ready_s;
  logic             xfer_s;
  logic             last_s;
  logic [DIV_W:0]   half_s;

  assign xfer_s = bus.cfg_valid & cfg_ready_r;
  assign last_s = (cnt_r == (div_r - DIV_W'(1)));

  // Next-state, counter and ratio sequencing.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    div_s      = div_r;
    pend_vld_s = pend_vld_r;
    pend_div_s = pend_div_r;
    case (state_r)
      IDLE: begin
        cnt_s = {DIV_W{1'b0}};
        if (xfer_s) begin
          div_s = clamp_div(bus.cfg_div);
        end else begin
          div_s = div_r;
        end
        if (bus.en) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          cnt_s      = {DIV_W{1'b0}};
          pend_vld_s = 1'b0;
          if (pend_vld_r) begin
            div_s = pend_div_r;
          end else begin
            div_s = div_r;
          end
          if (bus.en) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s   = cnt_r + DIV_W'(1);
          state_s = RUN;
        end
        // Only reachable with nothing pending, so it never collides with the clear above.
        if (xfer_s) begin
          pend_vld_s = 1'b1;
          pend_div_s = clamp_div(bus.cfg_div);
        end else begin
          pend_div_s = pend_div_r;
        end
      end
      default: begin
        state_s    = IDLE;
        cnt_s      = {DIV_W{1'b0}};
        pend_vld_s = 1'b0;
      end
    endcase
  end

  // Output values derived from next state so registered outputs line up with cnt.
  always_comb begin
    half_s      = ({1'b0, div_s} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    running_s   = (state_s == RUN);
    cfg_ready_s = ~pend_vld_s;
    if (state_s == RUN) begin
      clk_out_s = ({1'b0, cnt_s} < half_s);
      tick_s    = (cnt_s == {DIV_W{1'b0}});
    end else begin
      clk_out_s = 1'b0;
      tick_s    = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {DIV_W{1'b0}};
      div_r       <= DEF_DIV;
      pend_vld_r  <= 1'b0;
      pend_div_r  <= DEF_DIV;
      clk_out_r   <= 1'b0;
      tick_r      <= 1'b0;
      running_r   <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      div_r       <= div_s;
      pend_vld_r  <= pend_vld_s;
      pend_div_r  <= pend_div_s;
      clk_out_r   <= clk_out_s;
      tick_r      <= tick_s;
      running_r   <= running_s;
      cfg_ready_r <= cfg_ready_s;
    end
  end

  assign bus.cfg_ready = cfg_ready_r;
  assign bus.clk_out   = clk_out_r;
  assign bus.tick      = tick_r;
  assign bus.running   = running_r;
  assign bus.div_cur   = div_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a vector table for idle loading, odd ratios
// and clamping, plus hand-written sequences for multi-cycle corner cases.
module tb_clk_div_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_ticks;

  clk_div_if #(.DIV_W(8)) bus ();

  clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] div;
    logic       e_clk;
    logic       e_tick;
    logic       e_run;
    logic       e_rdy;
    logic [7:0] e_div;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic e_clk, input logic e_tick,
                         input logic e_run, input logic e_rdy, input logic [7:0] e_div);
    chk({name, ".clk_out"},   32'(bus.clk_out),   32'(e_clk));
    chk({name, ".tick"},      32'(bus.tick),      32'(e_tick));
    chk({name, ".running"},   32'(bus.running),   32'(e_run));
    chk({name, ".cfg_ready"}, 32'(bus.cfg_ready), 32'(e_rdy));
    chk({name, ".div_cur"},   32'(bus.div_cur),   32'(e_div));
  endtask

  task automatic step(input logic e, input logic v, input logic [7:0] d);
    bus.en        = e;
    bus.cfg_valid = v;
    bus.cfg_div   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_ticks  = 0;
    rst_n    = 1'b0;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = 8'd0;

    // {en, vld, div, clk_out, tick, running, cfg_ready, div_cur}; starts in IDLE with N=10
    tbl[0]  = '{1'b0, 1'b1, 8'd7,  1'b0, 1'b0, 1'b0, 1'b1, 8'd7};
    tbl[1]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'd7};
    tbl[2]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[3]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[4]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[5]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[6]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[7]  = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[8]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'd7};
    tbl[9]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[10] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[11] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[12] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[13] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[14] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd7};
    tbl[15] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd7};
    tbl[16] = '{1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 1'b1, 8'd5};
    tbl[17] = '{1'b0, 1'b1, 8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[18] = '{1'b0, 1'b1, 8'd3,  1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[19] = '{1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[20] = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
    tbl[21] = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[22] = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
    tbl[23] = '{1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[24] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[25] = '{1'b1, 1'b1, 8'd10, 1'b1, 1'b1, 1'b1, 1'b1, 8'd10};

    // Reset held with en high
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'd0);
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
    end

    // Default N=10 run: 5 high / 5 low, first tick one edge after release
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b0, 8'd0);
      chk_all("default_run", ((i % 10) < 5), ((i % 10) == 0), 1'b1, 1'b1, 8'd10);
      if (bus.tick) n_ticks++;
    end
    chk("default_tick_count", 32'(n_ticks), 32'd5);
    step(1'b0, 1'b0, 8'd0);
    chk_all("default_stop", 1'b0, 1'b0, 1'b0, 1'b1, 8'd10);

    // Table: odd ratio, stop mid-period, clamping, start with same-cycle load
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].en, tbl[i].vld, tbl[i].div);
      chk_all($sformatf("vec%0d", i), tbl[i].e_clk, tbl[i].e_tick,
              tbl[i].e_run, tbl[i].e_rdy, tbl[i].e_div);
    end

    // Mid-period reconfig to 4 at cnt=3, second offer held off, 1-cycle en glitch
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0);
    for (int k = 1; k <= 7; k++) begin
      step((k == 3) ? 1'b0 : 1'b1, (k < 7) ? 1'b1 : 1'b0, (k == 1) ? 8'd4 : 8'd6);
      chk_all($sformatf("reconfig_k%0d", k), (k == 1 || k == 7), (k == 7), 1'b1,
              (k == 7), (k == 7) ? 8'd4 : 8'd10);
    end
    for (int j = 1; j <= 8; j++) begin
      step(1'b1, 1'b0, 8'd0);
      chk_all($sformatf("n4_j%0d", j), ((j % 4) < 2), ((j % 4) == 0), 1'b1, 1'b1, 8'd4);
    end

    // Offer accepted on the boundary cycle applies one period later
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd10);
    chk_all("bnd_xfer", 1'b1, 1'b1, 1'b1, 1'b0, 8'd4);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 8'd0);
      chk_all($sformatf("bnd_hold%0d", i), (i < 2), 1'b0, 1'b1, 1'b0, 8'd4);
    end
    step(1'b1, 1'b0, 8'd0);
    chk_all("bnd_apply", 1'b1, 1'b1, 1'b1, 1'b1, 8'd10);

    // Stop requested at cnt=2: period completes, no runt phase
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 8'd0);
      chk_all($sformatf("stop_k%0d", k), (k <= 2), 1'b0, (k < 8), 1'b1, 8'd10);
    end
    step(1'b0, 1'b0, 8'd0);
    chk_all("stop_idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'd10);

    // Reset at cnt=2 with 4 pending: pending ratio discarded
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd4);
    chk_all("pend_before_rst", 1'b1, 1'b0, 1'b1, 1'b0, 8'd10);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 8'd0);
    chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'd0);
    chk_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'd10);
    for (int s = 1; s <= 12; s++) begin
      step(1'b1, 1'b0, 8'd0);
      chk_all($sformatf("post_reset_s%0d", s), (((s - 1) % 10) < 5), (s == 1 || s == 11),
              1'b1, 1'b1, 8'd10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
